// File: rtl/shift_seq_pkg.sv
// Shared types for the shift sequencer: FSM state encoding and direction names.
// ST_PARITY exists only when SHIFT_SEQ_PARITY_EN is defined.
package shift_seq_pkg;

    localparam string DIR_LEFT  = "LEFT";
    localparam string DIR_RIGHT = "RIGHT";

`ifdef SHIFT_SEQ_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd3
    } state_t;
`endif

endpackage

// File: rtl/shift_seq_datapath.sv
// Shift register with load and shift-enable, plus the serial-bit tap for the chosen direction.
// Latency: loaded word is visible the next cycle; backpressure is applied by holding i_shift_en low.
module shift_seq_datapath
    import shift_seq_pkg::*;
#(
    parameter int    DATA_W          = 8,
    parameter string SHIFT_DIRECTION = DIR_LEFT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_shift_en,
    output logic              o_ser_bit
);

    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shifted;

    // Any direction string other than RIGHT falls back to MSB-first.
    generate
        if (SHIFT_DIRECTION == DIR_RIGHT) begin : g_right
            assign w_shifted = {1'b0, r_shift[DATA_W-1:1]};
            assign o_ser_bit = r_shift[0];
        end else begin : g_left
            assign w_shifted = {r_shift[DATA_W-2:0], 1'b0};
            assign o_ser_bit = r_shift[DATA_W-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
        end else if (i_load) begin
            r_shift <= i_load_data;
        end else if (i_shift_en) begin
            r_shift <= w_shifted;
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Parallel-to-serial sequencer; optional trailing parity bit under SHIFT_SEQ_PARITY_EN.
// Latency: first bit the cycle after acceptance, done N+1 cycles after (N+2 with parity); bits stall on ser_ready=0.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int    DATA_W          = 8,
    parameter string SHIFT_DIRECTION = DIR_LEFT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [$clog2(DATA_W)-1:0]  in_len,
    input  logic                       abort,
    output logic                       ser_valid,
    input  logic                       ser_ready,
    output logic                       ser_bit,
    output logic                       busy,
    output logic                       done
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_load;
    logic             w_shift;
    logic             w_dp_bit;

    assign w_load  = (r_state == ST_IDLE) & in_valid;
    assign w_shift = (r_state == ST_SHIFT) & ser_ready & ~abort;

    shift_seq_datapath #(
        .DATA_W          (DATA_W),
        .SHIFT_DIRECTION (SHIFT_DIRECTION)
    ) u_datapath (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_load_data (in_data),
        .i_shift_en  (w_shift),
        .o_ser_bit   (w_dp_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Length 0 encodes a full DATA_W-bit word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= (in_len == '0) ? CNT_W'(DATA_W) : {1'b0, in_len};
        end else if (w_shift) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

`ifdef SHIFT_SEQ_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= 1'b0;
        end else if (w_shift) begin
            r_parity <= r_parity ^ w_dp_bit;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        ser_valid   = 1'b0;
        ser_bit     = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ser_valid = 1'b1;
                ser_bit   = w_dp_bit;
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (ser_ready && (r_cnt == CNT_W'(1))) begin
`ifdef SHIFT_SEQ_PARITY_EN
                    w_state_nxt = ST_PARITY;
`else
                    w_state_nxt = ST_DONE;
`endif
                end
            end
`ifdef SHIFT_SEQ_PARITY_EN
            ST_PARITY: begin
                ser_valid = 1'b1;
                ser_bit   = r_parity;
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (ser_ready) begin
                    w_state_nxt = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                // An abort landing on the done cycle still cancels the word.
                done        = ~abort;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench: two sequencers (LEFT and RIGHT) on a shared clock and reset.
module tb_shift_sequencer;

`ifdef SHIFT_SEQ_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [7:0] in_data   [2];
    logic [2:0] in_len    [2];
    logic       abort     [2];
    logic       ser_valid [2];
    logic       ser_ready [2];
    logic       ser_bit   [2];
    logic       busy      [2];
    logic       done      [2];

    int total = 0;
    int bad   = 0;

    bit   exp_q0[$];
    bit   exp_q1[$];
    logic prev_stall [2];
    logic prev_bit   [2];

    always #5 clk = ~clk;

    shift_sequencer #(.DATA_W(8), .SHIFT_DIRECTION("LEFT")) u_left (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_len(in_len[0]),
        .abort(abort[0]), .ser_valid(ser_valid[0]), .ser_ready(ser_ready[0]), .ser_bit(ser_bit[0]),
        .busy(busy[0]), .done(done[0])
    );

    shift_sequencer #(.DATA_W(8), .SHIFT_DIRECTION("RIGHT")) u_right (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_len(in_len[1]),
        .abort(abort[1]), .ser_valid(ser_valid[1]), .ser_ready(ser_ready[1]), .ser_bit(ser_bit[1]),
        .busy(busy[1]), .done(done[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input bit b);
        if (d == 0) exp_q0.push_back(b);
        else        exp_q1.push_back(b);
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    // Monitor: every accepted bit is popped against the scoreboard; stalls must hold.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                prev_stall[d] = 1'b0;
            end else begin
                if (prev_stall[d]) begin
                    check($sformatf("stall_hold_vld dut%0d", d), 32'(ser_valid[d]), 32'd1);
                    check($sformatf("stall_hold_bit dut%0d", d), 32'(ser_bit[d]), 32'(prev_bit[d]));
                end
                if (ser_valid[d] && ser_ready[d] && !abort[d]) begin
                    if (qsize(d) == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_bit dut%0d: got bit %0b expected no bit", d, ser_bit[d]);
                    end else begin
                        bit e;
                        if (d == 0) e = exp_q0.pop_front();
                        else        e = exp_q1.pop_front();
                        check($sformatf("ser_bit dut%0d", d), 32'(ser_bit[d]), 32'(e));
                    end
                end
                prev_stall[d] = ser_valid[d] && !ser_ready[d] && !abort[d];
                prev_bit[d]   = ser_bit[d];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // bits: send order with bits[n-1] first. mode 0: ready high; mode 1: ready 0,0,1 plus a stray in_valid.
    task automatic run_word(input int d, input logic [7:0] data, input logic [2:0] len,
                            input logic [15:0] bits, input int n, input bit par,
                            input int mode, input string name);
        int cyc;
        bit got;
        for (int i = n - 1; i >= 0; i--) push(d, bits[i]);
        if (PAR == 1) push(d, par);
        check({name, "_idle_ready"}, 32'(in_ready[d]), 32'd1);
        in_valid[d]  = 1'b1;
        in_data[d]   = data;
        in_len[d]    = len;
        ser_ready[d] = 1'b1;
        step();
        in_valid[d] = 1'b0;
        in_data[d]  = 8'h00;
        cyc = 1;
        got = 1'b0;
        while (!got && cyc < 200) begin
            ser_ready[d] = (mode == 0) || (cyc % 3 == 0);
            in_valid[d]  = (mode == 1) && (cyc == 2);
            in_data[d]   = 8'h5A;
            @(negedge clk);
            if (mode == 0 && cyc == 1) check({name, "_first_vld"}, 32'(ser_valid[d]), 32'd1);
            if (done[d]) got = 1'b1;
            else begin
                step();
                cyc++;
            end
        end
        in_valid[d] = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, cyc);
        end else if (mode == 0) begin
            check({name, "_done_latency"}, 32'(cyc), 32'(n + 1 + PAR));
        end
        check({name, "_bits_left"}, 32'(qsize(d)), 32'd0);
        ser_ready[d] = 1'b1;
        step();
        @(negedge clk);
        check({name, "_ready_after"}, 32'(in_ready[d]), 32'd1);
        check({name, "_busy_after"}, 32'(busy[d]), 32'd0);
        check({name, "_done_once"}, 32'(done[d]), 32'd0);
        step();
    endtask

    task automatic check_idle_outputs(input int d, input string name);
        check({name, "_in_ready"}, 32'(in_ready[d]), 32'd1);
        check({name, "_ser_valid"}, 32'(ser_valid[d]), 32'd0);
        check({name, "_ser_bit"}, 32'(ser_bit[d]), 32'd0);
        check({name, "_busy"}, 32'(busy[d]), 32'd0);
        check({name, "_done"}, 32'(done[d]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = 8'h00;
            in_len[d]    = 3'd0;
            abort[d]     = 1'b0;
            ser_ready[d] = 1'b1;
        end
        #1;
        check_idle_outputs(0, "in_reset_l");
        check_idle_outputs(1, "in_reset_r");
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs(0, "post_reset_l");
        step();

        // MSB-first full word.
        run_word(0, 8'hA5, 3'd0, 16'h00A5, 8, 1'b0, 0, "left_a5");
        // LSB-first short word, 3 bits.
        run_word(1, 8'hA5, 3'd3, 16'h0005, 3, 1'b0, 0, "right_a5_len3");
        // Single-bit length boundary.
        run_word(0, 8'h80, 3'd1, 16'h0001, 1, 1'b1, 0, "left_len1");
        // Longest non-zero length.
        run_word(1, 8'hFE, 3'd7, 16'h003F, 7, 1'b0, 0, "right_fe_len7");
        // Backpressure 0,0,1 with a stray load request mid-word.
        run_word(0, 8'h3C, 3'd0, 16'h003C, 8, 1'b0, 1, "left_3c_bp");

        // Abort in IDLE: no effect.
        abort[0] = 1'b1;
        step();
        abort[0] = 1'b0;
        @(negedge clk);
        check("abort_idle_ready", 32'(in_ready[0]), 32'd1);
        check("abort_idle_busy", 32'(busy[0]), 32'd0);
        step();

        // Abort after two bits of FF; the same-cycle handshake must not count.
        push(0, 1'b1);
        push(0, 1'b1);
        in_valid[0] = 1'b1;
        in_data[0]  = 8'hFF;
        in_len[0]   = 3'd0;
        step();
        in_valid[0] = 1'b0;
        step();
        step();
        abort[0] = 1'b1;
        @(negedge clk);
        check("abort_cycle_done", 32'(done[0]), 32'd0);
        step();
        abort[0] = 1'b0;
        @(negedge clk);
        check("abort_busy_next", 32'(busy[0]), 32'd0);
        check("abort_done_next", 32'(done[0]), 32'd0);
        check("abort_ready_next", 32'(in_ready[0]), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check("abort_no_done", 32'(done[0]), 32'd0);
        end
        check("abort_bits_left", 32'(qsize(0)), 32'd0);
        step();
        run_word(0, 8'h01, 3'd0, 16'h0001, 8, 1'b1, 0, "left_01_after_abort");

        // Parity build: 8'h07 carries parity 1 (3 ones).
        run_word(0, 8'h07, 3'd0, 16'h0007, 8, 1'b1, 0, "left_07");

        // Reset mid-word: three bits go out, then the word is discarded.
        push(0, 1'b0);
        push(0, 1'b0);
        push(0, 1'b1);
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h3C;
        in_len[0]   = 3'd0;
        step();
        in_valid[0] = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        check_idle_outputs(0, "mid_reset");
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mid_reset_bits_left", 32'(qsize(0)), 32'd0);
        check_idle_outputs(0, "after_mid_reset");
        step();
        run_word(0, 8'hA5, 3'd0, 16'h00A5, 8, 1'b0, 0, "left_a5_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter DATA_W, default 8, shift word width in bits; legal range 2..16.
REQ-002 Parameter SHIFT_DIRECTION, default "LEFT"; "LEFT" sends MSB first, "RIGHT" sends LSB first.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port in_valid  input  1  load request.
REQ-006 Port in_ready  output  1  sequencer can accept a word.
REQ-007 Port in_data  input  DATA_W  parallel word to serialise.
REQ-008 Port in_len  input  $clog2(DATA_W)  number of bits to send; 0 means DATA_W.
REQ-009 Port abort  input  1  synchronous cancel of the current word.
REQ-010 Port ser_valid  output  1  ser_bit is valid.
REQ-011 Port ser_ready  input  1  downstream accepts ser_bit.
REQ-012 Port ser_bit  output  1  current serial bit.
REQ-013 Port busy  output  1  high in every state except IDLE.
REQ-014 Port done  output  1  one-cycle pulse after the last bit is accepted.

Function
REQ-015 FSM states: IDLE, SHIFT, PARITY (present only with the macro), DONE.
REQ-016 IDLE: in_ready=1; on in_valid&in_ready, load in_data into the shift register, load bit counter with in_len (0 maps to DATA_W), go to SHIFT next cycle.
REQ-017 SHIFT: ser_valid=1; ser_bit = shift_reg[DATA_W-1] for LEFT, shift_reg[0] for RIGHT.
REQ-018 In SHIFT, ser_bit and ser_valid stay stable while ser_ready=0; no bit is ever dropped or repeated.
REQ-019 On ser_valid&ser_ready in SHIFT: shift the register one position, zero-filling, and decrement the counter.
REQ-020 When the counter goes 1->0 on a handshake, go to PARITY if compiled in, else to DONE.
REQ-021 DONE lasts exactly one cycle with done=1, then returns to IDLE; in_ready=0 in DONE.
REQ-022 Latency: first ser_valid is in the cycle after acceptance; with ser_ready tied high, done asserts N+1 cycles after acceptance (N+2 with parity).
REQ-023 abort in any non-IDLE state returns to IDLE next cycle without a done pulse; abort in IDLE has no effect.
REQ-024 abort and a same-cycle ser handshake: abort wins, and the bit counts as not sent.
REQ-025 in_valid is ignored while in_ready=0; no queuing.

Reset
REQ-026 While rst is high: state=IDLE, shift register=0, counter=0, parity accumulator=0.
REQ-027 Output values during and after reset: in_ready=1, ser_valid=0, ser_bit=0, busy=0, done=0.
REQ-028 Reset during SHIFT or PARITY discards the word, with no done pulse.

Configuration
REQ-029 Macro SHIFT_SEQ_PARITY_EN, when defined, adds the PARITY state, which sends one extra bit equal to the XOR of all data bits sent, under the same handshake rules.
REQ-030 Without SHIFT_SEQ_PARITY_EN: no PARITY state and no parity accumulator; SHIFT goes directly to DONE.

Structure
REQ-031 Package shift_seq_pkg holds the state enum typedef and the direction string constants "LEFT" and "RIGHT".
REQ-032 The datapath is sub-module shift_seq_datapath: load/shift-enable shift register plus serial-bit mux, parameterised by DATA_W and SHIFT_DIRECTION; the FSM and counter stay in shift_sequencer.

Verification
REQ-033 LEFT, DATA_W=8, in_data=8'hA5, in_len=0, ser_ready=1: ser_bit sequence 1,0,1,0,0,1,0,1; done 9 cycles after acceptance.
REQ-034 RIGHT, in_data=8'hA5, in_len=3: bits 1,0,1, then done; in_ready=1 again the cycle after done.
REQ-035 Backpressure: ser_ready toggles 0,0,1 repeatedly; ser_bit is held constant across stalls and all 8 bits of 8'h3C arrive in order.
REQ-036 Abort after 2 bits of 8'hFF: busy=0 next cycle, no done pulse; a following 8'h01 load sends 0,0,0,0,0,0,0,1.
REQ-037 SHIFT_SEQ_PARITY_EN defined, 8'h07, in_len=0: 8 data bits then parity bit 1, done 10 cycles after acceptance.
REQ-038 rst pulsed mid-SHIFT: outputs match REQ-027 immediately, and the next load proceeds normally.
